// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort datapath: loader states, default sizes
// and the slot-slicing helper for the flat array bus.
package sort_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_ELEM_DEF = 8;

  typedef enum logic {
    LOAD_FILL,
    LOAD_FULL
  } load_state_e;

  // Low bit of slot k on a flat bus of w-bit slots; use as bus[slot_lsb(k, w) +: w].
  function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/sort_array_loader_if.sv
// Handshake and array bus between the word source / sort core (master) and the loader (slave).
interface sort_array_loader_if
  import sort_pkg::*;
#(
  parameter int unsigned data_in_width = DATA_W_DEF,
  parameter int unsigned num_elem      = NUM_ELEM_DEF,
  parameter int unsigned idx_width     = $clog2(num_elem)
);

  logic                                in_valid;
  logic [data_in_width-1:0]            in_data;
  logic                                in_ready;
  logic                                flush;
  logic                                array_valid;
  logic                                array_ack;
  logic [num_elem*data_in_width-1:0]   array_out;
  logic [idx_width:0]                  fill_count;

  modport master (
    output in_valid, in_data, flush, array_ack,
    input  in_ready, array_valid, array_out, fill_count
  );

  modport slave (
    input  in_valid, in_data, flush, array_ack,
    output in_ready, array_valid, array_out, fill_count
  );

endinterface

// File: rtl/load_demux.sv
// 1-to-num_elem write demultiplexer: one-hot write enable for slot i_idx when i_en is set.
module load_demux #(
  parameter int unsigned num_elem  = 8,
  parameter int unsigned idx_width = $clog2(num_elem)
) (
  input  logic [idx_width-1:0] i_idx,
  input  logic                 i_en,
  output logic [num_elem-1:0]  o_we
);

  // Decode the index into a single write strobe, none when disabled.
  always_comb begin
    o_we = '0;
    if (i_en) begin
      o_we[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sort_array_loader.sv
// Fills the sort register bank from a valid/ready word stream, then holds the full
// bank on a flat bus until the sort core acknowledges it.
module sort_array_loader
  import sort_pkg::*;
#(
  parameter int unsigned data_in_width = DATA_W_DEF,
  parameter int unsigned num_elem      = NUM_ELEM_DEF,
  parameter int unsigned idx_width     = $clog2(num_elem)
) (
  input  logic              clk,
  input  logic              rst,
  sort_array_loader_if.slave bus
);

  localparam logic [idx_width-1:0] LAST_IDX = idx_width'(num_elem - 1);
  localparam logic [idx_width:0]   FULL_CNT = (idx_width + 1)'(num_elem);

  load_state_e              r_state;
  logic [idx_width-1:0]     r_wr_idx;
  logic [idx_width:0]       r_fill_count;
  logic                     r_in_ready;
  logic                     r_array_valid;
  logic [data_in_width-1:0] r_slot [num_elem];

  logic                     w_accept;
  logic                     w_wr_en;
  logic [num_elem-1:0]      w_we;
  logic [num_elem*data_in_width-1:0] w_array_out;

  // r_in_ready is only high in FILL, so it alone qualifies an accept; flush drops the word.
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_wr_en  = w_accept & ~bus.flush;

  load_demux #(
    .num_elem  (num_elem),
    .idx_width (idx_width)
  ) u_load_demux (
    .i_idx (r_wr_idx),
    .i_en  (w_wr_en),
    .o_we  (w_we)
  );

  // Fill/hold state machine with registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= LOAD_FILL;
      r_wr_idx      <= '0;
      r_fill_count  <= '0;
      r_in_ready    <= 1'b1;
      r_array_valid <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD_FILL: begin
          if (bus.flush) begin
            r_wr_idx     <= '0;
            r_fill_count <= '0;
          end else if (w_accept) begin
            if (r_wr_idx == LAST_IDX) begin
              r_state       <= LOAD_FULL;
              r_wr_idx      <= '0;
              r_fill_count  <= FULL_CNT;
              r_in_ready    <= 1'b0;
              r_array_valid <= 1'b1;
            end else begin
              r_wr_idx     <= r_wr_idx + idx_width'(1);
              r_fill_count <= r_fill_count + (idx_width + 1)'(1);
            end
          end
        end
        LOAD_FULL: begin
          // flush in FULL behaves exactly like an ack
          if (bus.array_ack || bus.flush) begin
            r_state       <= LOAD_FILL;
            r_wr_idx      <= '0;
            r_fill_count  <= '0;
            r_in_ready    <= 1'b1;
            r_array_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= LOAD_FILL;
        end
      endcase
    end
  end

  // Slot bank: written only on a strobe, so in_data is never sampled while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(num_elem); k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(num_elem); k++) begin
        if (w_we[k]) begin
          r_slot[k] <= bus.in_data;
        end
      end
    end
  end

  // Pack the slots onto the flat bus, slot 0 in the low bits.
  always_comb begin
    w_array_out = '0;
    for (int k = 0; k < int'(num_elem); k++) begin
      w_array_out[slot_lsb(k, data_in_width) +: data_in_width] = r_slot[k];
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.array_valid = r_array_valid;
  assign bus.array_out   = w_array_out;
  assign bus.fill_count  = r_fill_count;

endmodule

// File: tb/tb_sort_array_loader.sv
// Directed and randomized checks of sort_array_loader with a 4-slot, 16-bit bank.
module tb_sort_array_loader;
  import sort_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NE = 4;
  localparam int unsigned IW = $clog2(NE);

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Independent model for the randomized phase.
  bit          m_full;
  int          m_idx;
  int          m_cnt;
  logic [DW-1:0] m_slot [NE];
  logic [63:0] m_out;

  sort_array_loader_if #(
    .data_in_width (DW),
    .num_elem      (NE),
    .idx_width     (IW)
  ) bus ();

  sort_array_loader #(
    .data_in_width (DW),
    .num_elem      (NE),
    .idx_width     (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.array_ack = 1'b0;

    // Reset state
    #12;
    check("rst_count", 64'(bus.fill_count), 64'd0);
    check("rst_valid", 64'(bus.array_valid), 64'd0);
    check("rst_out", bus.array_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back fill
    push(16'h0011);
    push(16'h0022);
    check("b2b_count2", 64'(bus.fill_count), 64'd2);
    push(16'h0033);
    check("b2b_valid3", 64'(bus.array_valid), 64'd0);
    push(16'h0044);
    check("b2b_valid", 64'(bus.array_valid), 64'd1);
    check("b2b_out", bus.array_out, 64'h0044_0033_0022_0011);
    check("b2b_count", 64'(bus.fill_count), 64'd4);
    check("b2b_ready", 64'(bus.in_ready), 64'd0);

    // Hold in FULL with traffic, then ack
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    repeat (5) tick();
    check("hold_out", bus.array_out, 64'h0044_0033_0022_0011);
    check("hold_count", 64'(bus.fill_count), 64'd4);
    check("hold_valid", 64'(bus.array_valid), 64'd1);
    bus.array_ack = 1'b1;
    tick();
    bus.array_ack = 1'b0;
    bus.in_valid  = 1'b0;
    check("ack_ready", 64'(bus.in_ready), 64'd1);
    check("ack_count", 64'(bus.fill_count), 64'd0);
    check("ack_valid", 64'(bus.array_valid), 64'd0);
    check("ack_out_kept", bus.array_out, 64'h0044_0033_0022_0011);

    // Gaps in in_valid; in_data is junk when idle
    push(16'h00A1);
    bus.in_data = 16'hFFFF;
    tick();
    push(16'h00A2);
    push(16'h00A3);
    bus.in_data = 16'hFFFF;
    tick();
    check("gap_count5", 64'(bus.fill_count), 64'd3);
    check("gap_valid5", 64'(bus.array_valid), 64'd0);
    push(16'h00A4);
    check("gap_valid6", 64'(bus.array_valid), 64'd1);
    check("gap_out", bus.array_out, 64'h00A4_00A3_00A2_00A1);
    bus.array_ack = 1'b1;
    tick();
    bus.array_ack = 1'b0;

    // Flush mid-fill wins over a simultaneous accept
    push(16'h0101);
    push(16'h0202);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_count", 64'(bus.fill_count), 64'd0);
    check("flush_out", bus.array_out, 64'h00A4_00A3_0202_0101);
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    check("refill_out", bus.array_out, 64'h4444_3333_2222_1111);
    check("refill_valid", 64'(bus.array_valid), 64'd1);

    // Flush in FULL acts as ack
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fullflush_valid", 64'(bus.array_valid), 64'd0);
    check("fullflush_ready", 64'(bus.in_ready), 64'd1);
    check("fullflush_count", 64'(bus.fill_count), 64'd0);

    // flush + ack together is a single ack
    push(16'h5555);
    push(16'h6666);
    push(16'h7777);
    push(16'h8888);
    bus.flush     = 1'b1;
    bus.array_ack = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.array_ack = 1'b0;
    check("both_valid", 64'(bus.array_valid), 64'd0);
    push(16'h9999);
    check("both_count", 64'(bus.fill_count), 64'd1);
    check("both_out", bus.array_out, 64'h8888_7777_6666_9999);

    // ack while filling is ignored
    bus.array_ack = 1'b1;
    tick();
    bus.array_ack = 1'b0;
    check("fillack_count", 64'(bus.fill_count), 64'd1);

    // Async reset mid-cycle while FULL
    push(16'h0AAA);
    push(16'h0BBB);
    push(16'h0CCC);
    check("prerst_valid", 64'(bus.array_valid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.array_valid), 64'd0);
    check("arst_out", bus.array_out, 64'd0);
    check("arst_count", 64'(bus.fill_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_ready", 64'(bus.in_ready), 64'd1);

    // Random stress against the model
    m_full = 1'b0;
    m_idx  = 0;
    m_cnt  = 0;
    for (int k = 0; k < int'(NE); k++) m_slot[k] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = DW'($urandom);
      bus.array_ack = ($urandom_range(0, 4) == 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      if (!m_full) begin
        if (bus.flush) begin
          m_idx = 0;
          m_cnt = 0;
        end else if (bus.in_valid) begin
          m_slot[m_idx] = bus.in_data;
          if (m_idx == int'(NE) - 1) begin
            m_full = 1'b1;
            m_idx  = 0;
            m_cnt  = NE;
          end else begin
            m_idx++;
            m_cnt++;
          end
        end
      end else if (bus.array_ack || bus.flush) begin
        m_full = 1'b0;
        m_idx  = 0;
        m_cnt  = 0;
      end
      tick();
      m_out = '0;
      for (int k = 0; k < int'(NE); k++) m_out[slot_lsb(k, DW) +: DW] = m_slot[k];
      check("rnd_ready", 64'(bus.in_ready), 64'(!m_full));
      check("rnd_valid", 64'(bus.array_valid), 64'(m_full));
      check("rnd_count", 64'(bus.fill_count), 64'(m_cnt));
      check("rnd_out", bus.array_out, m_out);
    end
    bus.in_valid  = 1'b0;
    bus.array_ack = 1'b0;
    bus.flush     = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
